pipeline_interlock: RTL and testbench

PIPELINE_INTERLOCK -- requirements
Module: pipeline_interlock

---
 rtl/pipeline_interlock_pkg.sv | 32 +++
 rtl/pipeline_interlock_if.sv | 51 +++++
 rtl/pipeline_interlock_operand_fwd_mux.sv | 30 +++
 rtl/pipeline_interlock.sv | 136 +++++++++++++
 tb/tb_pipeline_interlock.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/pipeline_interlock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_interlock_pkg
// Description : Shared CPU constants for the ID/EX interlock: data width,
//               event counter width, FSM encodings and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_interlock_pkg;

   localparam int XLEN    = 32;
   localparam int CNT_W   = 16;
   localparam int STATE_W = 2;

   localparam logic [STATE_W-1:0] ST_RUN        = 2'd0;
   localparam logic [STATE_W-1:0] ST_LOAD_STALL = 2'd1;
   localparam logic [STATE_W-1:0] ST_FLUSH      = 2'd2;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Forwarding request pair for one operand side.
   typedef struct packed {
      logic fwd_ex;
      logic fwd_mem;
   } fwd_sel_t;

   // Increment that sticks at the all-ones value instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_interlock_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_interlock_if
// Description : Bundle of operand, hazard-control and status signals that
//               connect the hazard unit / datapath to the ID/EX interlock.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_interlock_if;
   import pipeline_interlock_pkg::*;

   logic [XLEN-1:0]  rs1_data;
   logic [XLEN-1:0]  rs2_data;
   logic [XLEN-1:0]  ex_result;
   logic [XLEN-1:0]  mem_result;
   logic             forward_EX_A;
   logic             forward_EX_B;
   logic             forward_MEM_A;
   logic             forward_MEM_B;
   logic             stop_ID;
   logic             flush_EX;
   logic             id_valid;

   logic [XLEN-1:0]  op_a_EX;
   logic [XLEN-1:0]  op_b_EX;
   logic             valid_EX;
   logic             pc_en;
   logic             if_id_en;
   logic             if_id_flush;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   // Driver side (pipeline datapath / hazard detection).
   modport master (
      output rs1_data, rs2_data, ex_result, mem_result,
      output forward_EX_A, forward_EX_B, forward_MEM_A, forward_MEM_B,
      output stop_ID, flush_EX, id_valid,
      input  op_a_EX, op_b_EX, valid_EX, pc_en, if_id_en, if_id_flush,
      input  stall_cnt, flush_cnt
   );

   // Interlock side.
   modport slave (
      input  rs1_data, rs2_data, ex_result, mem_result,
      input  forward_EX_A, forward_EX_B, forward_MEM_A, forward_MEM_B,
      input  stop_ID, flush_EX, id_valid,
      output op_a_EX, op_b_EX, valid_EX, pc_en, if_id_en, if_id_flush,
      output stall_cnt, flush_cnt
   );

endinterface
`default_nettype wire

// File: rtl/pipeline_interlock_operand_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : operand_fwd_mux
// Description : Selects one EX operand from EX result, MEM result or the
//               register-file value. The EX result is the youngest value,
//               so it wins when both forwarding flags are raised.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fwd_mux
   import pipeline_interlock_pkg::*;
(
   input  fwd_sel_t        sel,
   input  logic [XLEN-1:0] reg_data,
   input  logic [XLEN-1:0] ex_result,
   input  logic [XLEN-1:0] mem_result,
   output logic [XLEN-1:0] operand
);

   // Priority select: EX over MEM over register file.
   always_comb begin
      operand = reg_data;
      if (sel.fwd_ex) begin
         operand = ex_result;
      end else if (sel.fwd_mem) begin
         operand = mem_result;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pipeline_interlock.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_interlock
// Description : ID/EX interlock. Forwards operands into the ID/EX register,
//               inserts bubbles on load-use stalls and taken branches,
//               gates PC / IF-ID writes, and counts stall/flush events.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_interlock
   import pipeline_interlock_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   pipeline_interlock_if.slave  bus
);

   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] w_state_nxt;

   logic [XLEN-1:0]    w_op_a_sel;
   logic [XLEN-1:0]    w_op_b_sel;
   logic [XLEN-1:0]    r_op_a;
   logic [XLEN-1:0]    r_op_b;
   logic               r_valid;
   logic [CNT_W-1:0]   r_stall_cnt;
   logic [CNT_W-1:0]   r_flush_cnt;

   logic               w_pc_en;
   logic               w_if_id_flush;

   // A stall only counts when no flush is present: the flush kills the
   // stalled instruction anyway, so the front end must keep moving.
   logic               w_stall_req;
   logic               w_bubble;

   assign w_stall_req = bus.stop_ID & ~bus.flush_EX;
   assign w_bubble    = bus.stop_ID | bus.flush_EX;

   operand_fwd_mux u_fwd_a (
      .sel        ('{fwd_ex: bus.forward_EX_A, fwd_mem: bus.forward_MEM_A}),
      .reg_data   (bus.rs1_data),
      .ex_result  (bus.ex_result),
      .mem_result (bus.mem_result),
      .operand    (w_op_a_sel)
   );

   operand_fwd_mux u_fwd_b (
      .sel        ('{fwd_ex: bus.forward_EX_B, fwd_mem: bus.forward_MEM_B}),
      .reg_data   (bus.rs2_data),
      .ex_result  (bus.ex_result),
      .mem_result (bus.mem_result),
      .operand    (w_op_b_sel)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state: flush always beats stall, whatever the current state.
   always_comb begin
      w_state_nxt = ST_RUN;
      case (r_state)
         ST_RUN: begin
            if (bus.flush_EX)      w_state_nxt = ST_FLUSH;
            else if (bus.stop_ID)  w_state_nxt = ST_LOAD_STALL;
            else                   w_state_nxt = ST_RUN;
         end
         ST_LOAD_STALL: begin
            if (bus.flush_EX)      w_state_nxt = ST_FLUSH;
            else if (bus.stop_ID)  w_state_nxt = ST_LOAD_STALL;
            else                   w_state_nxt = ST_RUN;
         end
         ST_FLUSH: begin
            if (bus.flush_EX)      w_state_nxt = ST_FLUSH;
            else if (bus.stop_ID)  w_state_nxt = ST_LOAD_STALL;
            else                   w_state_nxt = ST_RUN;
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   // FSM outputs: front-end enables and IF/ID clear; reset freezes the
   // front end and holds IF/ID cleared.
   always_comb begin
      w_pc_en       = 1'b0;
      w_if_id_flush = 1'b1;
      if (reset) begin
         w_pc_en       = ~w_stall_req;
         w_if_id_flush = bus.flush_EX;
      end
   end

   // ID/EX register: bubble (zeroed operands, valid low) on stall or flush.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_valid <= 1'b0;
         r_op_a  <= '0;
         r_op_b  <= '0;
      end else if (w_bubble) begin
         r_valid <= 1'b0;
         r_op_a  <= '0;
         r_op_b  <= '0;
      end else begin
         r_valid <= bus.id_valid;
         r_op_a  <= w_op_a_sel;
         r_op_b  <= w_op_b_sel;
      end
   end

   // Saturating stall and flush event counters.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall_req)  r_stall_cnt <= sat_inc(r_stall_cnt);
         if (bus.flush_EX) r_flush_cnt <= sat_inc(r_flush_cnt);
      end
   end

   assign bus.op_a_EX     = r_op_a;
   assign bus.op_b_EX     = r_op_b;
   assign bus.valid_EX    = r_valid;
   assign bus.pc_en       = w_pc_en;
   assign bus.if_id_en    = w_pc_en;
   assign bus.if_id_flush = w_if_id_flush;
   assign bus.stall_cnt   = r_stall_cnt;
   assign bus.flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_interlock.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_interlock
// Description : Directed self-checking bench for pipeline_interlock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_interlock;
   import pipeline_interlock_pkg::*;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   pipeline_interlock_if bus ();

   pipeline_interlock dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset             = 1'b0;
      bus.rs1_data      = '0;
      bus.rs2_data      = '0;
      bus.ex_result     = '0;
      bus.mem_result    = '0;
      bus.forward_EX_A  = 1'b0;
      bus.forward_EX_B  = 1'b0;
      bus.forward_MEM_A = 1'b0;
      bus.forward_MEM_B = 1'b0;
      bus.stop_ID       = 1'b0;
      bus.flush_EX      = 1'b0;
      bus.id_valid      = 1'b0;

      // Reset state and front-end gating during reset.
      tick();
      tick();
      chk("rst_pc_en",     {31'd0, bus.pc_en},       32'd0);
      chk("rst_if_id_en",  {31'd0, bus.if_id_en},    32'd0);
      chk("rst_if_flush",  {31'd0, bus.if_id_flush}, 32'd1);
      chk("rst_valid",     {31'd0, bus.valid_EX},    32'd0);
      chk("rst_op_a",      bus.op_a_EX,              32'd0);
      chk("rst_op_b",      bus.op_b_EX,              32'd0);
      chk("rst_stall_cnt", {16'd0, bus.stall_cnt},   32'd0);
      chk("rst_flush_cnt", {16'd0, bus.flush_cnt},   32'd0);
      chk("rst_state",     {30'd0, dut.r_state},     {30'd0, ST_RUN});

      // No hazards: register values pass through with one-cycle latency.
      reset        = 1'b1;
      bus.rs1_data = 32'd5;
      bus.rs2_data = 32'd7;
      bus.id_valid = 1'b1;
      #1;
      chk("run_pc_en",    {31'd0, bus.pc_en},       32'd1);
      chk("run_if_id_en", {31'd0, bus.if_id_en},    32'd1);
      chk("run_if_flush", {31'd0, bus.if_id_flush}, 32'd0);
      tick();
      chk("run_op_a",  bus.op_a_EX,           32'd5);
      chk("run_op_b",  bus.op_b_EX,           32'd7);
      chk("run_valid", {31'd0, bus.valid_EX}, 32'd1);

      // EX beats MEM on side A; MEM alone on side B.
      bus.forward_EX_A  = 1'b1;
      bus.forward_MEM_A = 1'b1;
      bus.forward_MEM_B = 1'b1;
      bus.ex_result     = 32'hAA;
      bus.mem_result    = 32'hBB;
      tick();
      chk("fwd_a_ex_wins", bus.op_a_EX, 32'hAA);
      chk("fwd_b_mem",     bus.op_b_EX, 32'hBB);

      // EX forward only on side B; side A back to register data, invalid ID.
      bus.forward_EX_A  = 1'b0;
      bus.forward_MEM_A = 1'b0;
      bus.forward_MEM_B = 1'b0;
      bus.forward_EX_B  = 1'b1;
      bus.id_valid      = 1'b0;
      tick();
      chk("fwd_a_reg",   bus.op_a_EX,           32'd5);
      chk("fwd_b_ex",    bus.op_b_EX,           32'hAA);
      chk("idv0_valid",  {31'd0, bus.valid_EX}, 32'd0);
      bus.forward_EX_B = 1'b0;
      bus.id_valid     = 1'b1;

      // Single-cycle load-use stall.
      bus.stop_ID = 1'b1;
      #1;
      chk("ls_pc_en",    {31'd0, bus.pc_en},       32'd0);
      chk("ls_if_id_en", {31'd0, bus.if_id_en},    32'd0);
      chk("ls_if_flush", {31'd0, bus.if_id_flush}, 32'd0);
      tick();
      chk("ls_valid",     {31'd0, bus.valid_EX},  32'd0);
      chk("ls_op_a",      bus.op_a_EX,            32'd0);
      chk("ls_state",     {30'd0, dut.r_state},   {30'd0, ST_LOAD_STALL});
      chk("ls_stall_cnt", {16'd0, bus.stall_cnt}, 32'd1);
      bus.stop_ID = 1'b0;
      tick();
      chk("ls_back_state", {30'd0, dut.r_state},  {30'd0, ST_RUN});
      chk("ls_back_valid", {31'd0, bus.valid_EX}, 32'd1);
      chk("ls_back_op_a",  bus.op_a_EX,           32'd5);

      // Stall and flush together: flush wins.
      bus.stop_ID  = 1'b1;
      bus.flush_EX = 1'b1;
      #1;
      chk("sf_pc_en",    {31'd0, bus.pc_en},       32'd1);
      chk("sf_if_flush", {31'd0, bus.if_id_flush}, 32'd1);
      tick();
      chk("sf_state",     {30'd0, dut.r_state},   {30'd0, ST_FLUSH});
      chk("sf_flush_cnt", {16'd0, bus.flush_cnt}, 32'd1);
      chk("sf_stall_cnt", {16'd0, bus.stall_cnt}, 32'd1);
      chk("sf_valid",     {31'd0, bus.valid_EX},  32'd0);

      // Back-to-back flush: one bubble per flush cycle.
      bus.stop_ID = 1'b0;
      tick();
      chk("ff_state",     {30'd0, dut.r_state},   {30'd0, ST_FLUSH});
      chk("ff_flush_cnt", {16'd0, bus.flush_cnt}, 32'd2);
      chk("ff_valid",     {31'd0, bus.valid_EX},  32'd0);

      // FLUSH -> LOAD_STALL.
      bus.flush_EX = 1'b0;
      bus.stop_ID  = 1'b1;
      tick();
      chk("fl_ls_state",     {30'd0, dut.r_state},   {30'd0, ST_LOAD_STALL});
      chk("fl_ls_stall_cnt", {16'd0, bus.stall_cnt}, 32'd2);

      // Reset in the middle of a stall.
      reset = 1'b0;
      #1;
      chk("mr_pc_en",    {31'd0, bus.pc_en},       32'd0);
      chk("mr_if_flush", {31'd0, bus.if_id_flush}, 32'd1);
      tick();
      chk("mr_state",     {30'd0, dut.r_state},   {30'd0, ST_RUN});
      chk("mr_stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
      chk("mr_flush_cnt", {16'd0, bus.flush_cnt}, 32'd0);
      chk("mr_valid",     {31'd0, bus.valid_EX},  32'd0);

      // First cycle after release behaves as RUN.
      reset        = 1'b1;
      bus.stop_ID  = 1'b0;
      bus.rs1_data = 32'd9;
      tick();
      chk("rel_state", {30'd0, dut.r_state},  {30'd0, ST_RUN});
      chk("rel_valid", {31'd0, bus.valid_EX}, 32'd1);
      chk("rel_op_a",  bus.op_a_EX,           32'd9);

      // Stall counter saturation: climb to 0xFFFE, then 3 more stalls.
      bus.stop_ID = 1'b1;
      for (int i = 0; i < 65534; i++) @(posedge clk);
      #1;
      chk("sat_pre",  {16'd0, bus.stall_cnt}, 32'h0000FFFE);
      tick();
      tick();
      tick();
      chk("sat_max",  {16'd0, bus.stall_cnt}, 32'h0000FFFF);
      bus.stop_ID = 1'b0;
      tick();
      chk("sat_hold", {16'd0, bus.stall_cnt}, 32'h0000FFFF);
      chk("sat_flush_cnt", {16'd0, bus.flush_cnt}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
